// File: rtl/stitch_pkg.sv
// Shared definitions for the two-camera stitch scheduler: default geometry,
// FSM state encoding and a frame-size helper.
package stitch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LINE_W_DEF = 4;
  localparam int LINES_DEF  = 2;

  // Pixels captured per camera frame.
  function automatic int frame_px(input int line_w, input int lines);
    return line_w * lines;
  endfunction

  localparam int FRAME_PX = frame_px(LINE_W_DEF, LINES_DEF);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP0 = 3'd1,
    CAP1 = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/stitch_addr_gen.sv
// Combinational read-order address map: index k walks the stitched output
// raster (cam0 line segment, then cam1 line segment) and is translated to
// the buffer location, with cam1 stored in the upper half.
module stitch_addr_gen
  import stitch_pkg::*;
#(
  parameter int LINE_W     = LINE_W_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int FRAME_PX_P = FRAME_PX,
  parameter int ADDR_W     = $clog2(2 * LINE_W * LINES)
) (
  input  logic [ADDR_W-1:0] k,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] line_s;
  logic [ADDR_W-1:0] col_s;

  // Split k into stitched line/column and pick the camera half.
  always_comb begin
    line_s = k / ADDR_W'(2 * LINE_W);
    col_s  = k % ADDR_W'(2 * LINE_W);
    if (col_s < ADDR_W'(LINE_W)) begin
      addr = line_s * ADDR_W'(LINE_W) + col_s;
    end else begin
      addr = ADDR_W'(FRAME_PX_P) + line_s * ADDR_W'(LINE_W) + (col_s - ADDR_W'(LINE_W));
    end
  end

endmodule

// File: rtl/stitch_scheduler.sv
// Frame-buffer sequencer for a two-camera stitcher: captures one cam0 frame
// and one cam1 frame into disjoint buffer halves, then reads them back
// side-by-side to a ready/valid pixel sink.
// Optional feature macro: STITCH_CHECKSUM_EN (16-bit running sum of output
// pixels on the checksum port; tied to zero when undefined).
module stitch_scheduler
  import stitch_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int LINE_W = LINE_W_DEF,
  parameter  int LINES  = LINES_DEF,
  localparam int ADDR_W = $clog2(2 * LINE_W * LINES)
) (
  input  logic              clk,
  input  logic              erst,
  input  logic              start,
  input  logic              pause,
  output logic [1:0]        cam_enable,
  input  logic [1:0]        cam_valid,
  input  logic [DATA_W-1:0] cam0_data,
  input  logic [DATA_W-1:0] cam1_data,
  output logic              mem_on,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  localparam int                CAM_PX    = frame_px(LINE_W, LINES);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(CAM_PX - 1);
  localparam logic [ADDR_W-1:0] CAM1_BASE = ADDR_W'(CAM_PX);
  localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(2 * CAM_PX - 1);

  state_t            state_r;
  state_t            state_nx_s;
  logic [ADDR_W-1:0] pix_r;
  logic [ADDR_W-1:0] k_r;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_pending_r;
  logic              issued_all_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              busy_r;
  logic              done_r;
  logic              wr_s;
  logic              rd_s;
  logic              hs_s;
  logic              start_ok_s;

  stitch_addr_gen #(
    .LINE_W     (LINE_W),
    .LINES      (LINES),
    .FRAME_PX_P (CAM_PX),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .k    (k_r),
    .addr (rd_addr_s)
  );

  assign hs_s       = out_valid_r && out_ready;
  assign start_ok_s = (state_r == IDLE) && start;

  // Next-state and memory/camera strobes; a write or read only happens in
  // the same cycle its qualifying inputs are seen.
  always_comb begin
    state_nx_s = state_r;
    cam_enable = 2'b00;
    wr_s       = 1'b0;
    rd_s       = 1'b0;
    mem_on     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = CAP0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CAP0: begin
        if (!pause) begin
          cam_enable = 2'b01;
          if (cam_valid[0]) begin
            wr_s      = 1'b1;
            mem_on    = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = pix_r;
            mem_wdata = cam0_data;
            if (pix_r == PIX_LAST) begin
              state_nx_s = CAP1;
            end else begin
              state_nx_s = CAP0;
            end
          end else begin
            state_nx_s = CAP0;
          end
        end else begin
          state_nx_s = CAP0;
        end
      end
      CAP1: begin
        if (!pause) begin
          cam_enable = 2'b10;
          if (cam_valid[1]) begin
            wr_s      = 1'b1;
            mem_on    = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = CAM1_BASE + pix_r;
            mem_wdata = cam1_data;
            if (pix_r == PIX_LAST) begin
              state_nx_s = READ;
            end else begin
              state_nx_s = CAP1;
            end
          end else begin
            state_nx_s = CAP1;
          end
        end else begin
          state_nx_s = CAP1;
        end
      end
      READ: begin
        // One read in flight at most; the output register must be empty.
        if (!rd_pending_r && !out_valid_r && !pause && !issued_all_r) begin
          rd_s     = 1'b1;
          mem_on   = 1'b1;
          mem_addr = rd_addr_s;
        end else begin
          rd_s = 1'b0;
        end
        if (hs_s && issued_all_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = READ;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge erst) begin
    if (!erst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture pixel counter, shared by both camera phases.
  always_ff @(posedge clk or negedge erst) begin
    if (!erst) begin
      pix_r <= {ADDR_W{1'b0}};
    end else if (start_ok_s) begin
      pix_r <= {ADDR_W{1'b0}};
    end else if (wr_s) begin
      if (pix_r == PIX_LAST) begin
        pix_r <= {ADDR_W{1'b0}};
      end else begin
        pix_r <= pix_r + ADDR_W'(1);
      end
    end else begin
      pix_r <= pix_r;
    end
  end

  // Read index and in-flight tracking.
  always_ff @(posedge clk or negedge erst) begin
    if (!erst) begin
      k_r          <= {ADDR_W{1'b0}};
      issued_all_r <= 1'b0;
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= rd_s;
      if (start_ok_s) begin
        k_r          <= {ADDR_W{1'b0}};
        issued_all_r <= 1'b0;
      end else if (rd_s) begin
        k_r <= k_r + ADDR_W'(1);
        if (k_r == K_LAST) begin
          issued_all_r <= 1'b1;
        end else begin
          issued_all_r <= issued_all_r;
        end
      end else begin
        k_r          <= k_r;
        issued_all_r <= issued_all_r;
      end
    end
  end

  // Output register: load returning read data, hold until the sink takes it.
  always_ff @(posedge clk or negedge erst) begin
    if (!erst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else if (rd_pending_r) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mem_rdata;
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge erst) begin
    if (!erst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != IDLE);
      done_r <= (state_nx_s == DONE);
    end
  end

`ifdef STITCH_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Running modular sum of accepted output pixels, restarted by each run.
  always_ff @(posedge clk or negedge erst) begin
    if (!erst) begin
      checksum_r <= 16'h0000;
    end else if (start_ok_s) begin
      checksum_r <= 16'h0000;
    end else if (hs_s) begin
      checksum_r <= checksum_r + 16'(out_data_r);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 16'h0000;
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_stitch_scheduler.sv
// Directed bench for stitch_scheduler with a behavioural buffer memory.
module tb_stitch_scheduler;

  logic       clk;
  logic       erst;
  logic       start;
  logic       pause;
  logic [1:0] cam_enable;
  logic [1:0] cam_valid;
  logic [7:0] cam0_data;
  logic [7:0] cam1_data;
  logic       mem_on;
  logic       mem_rw;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [15:0] checksum;

  logic [7:0] mem_model [16];
  logic [7:0] exp_data  [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                                 8'h04, 8'h05, 8'h06, 8'h07, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [3:0] exp_addr  [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11,
                                 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15};

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  stitch_scheduler dut (
    .clk        (clk),
    .erst       (erst),
    .start      (start),
    .pause      (pause),
    .cam_enable (cam_enable),
    .cam_valid  (cam_valid),
    .cam0_data  (cam0_data),
    .cam1_data  (cam1_data),
    .mem_on     (mem_on),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous buffer memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_on && mem_rw) mem_model[mem_addr] <= mem_wdata;
    if (mem_on && !mem_rw) mem_rdata <= mem_model[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [1:0] vmask, input logic [7:0] d, input logic [3:0] a);
    cam_valid = vmask;
    if (vmask[0]) cam0_data = d;
    else cam1_data = d;
    #1;
    check("wr_on",   32'(mem_on),    32'h1);
    check("wr_rw",   32'(mem_rw),    32'h1);
    check("wr_addr", 32'(mem_addr),  32'(a));
    check("wr_data", 32'(mem_wdata), 32'(d));
    tick();
    cam_valid = 2'b00;
  endtask

  initial begin
    int idx, rd_k, done_cnt, bp_left, pz_left;
    bit bp_done, pz_done;
    logic [15:0] exp_sum;
    idx = 0; rd_k = 0; done_cnt = 0; bp_left = 0; pz_left = 0;
    bp_done = 1'b0; pz_done = 1'b0;
`ifdef STITCH_CHECKSUM_EN
    exp_sum = 16'h00B8;
`else
    exp_sum = 16'h0000;
`endif
    for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
    mem_rdata = 8'h00;
    erst = 1'b0; start = 1'b0; pause = 1'b0; cam_valid = 2'b00;
    cam0_data = 8'h00; cam1_data = 8'h00; out_ready = 1'b1;
    tick();
    check("rst_busy",   32'(busy),       32'h0);
    check("rst_camen",  32'(cam_enable), 32'h0);
    check("rst_memon",  32'(mem_on),     32'h0);
    check("rst_oval",   32'(out_valid),  32'h0);
    check("rst_done",   32'(done),       32'h0);
    check("rst_csum",   32'(checksum),   32'h0);
    erst = 1'b1;
    tick();

    // start together with pause: accepted, capture waits
    start = 1'b1; pause = 1'b1;
    tick();
    start = 1'b0; cam_valid = 2'b01; cam0_data = 8'hEE;
    #1;
    check("sp_busy",  32'(busy),       32'h1);
    check("sp_camen", 32'(cam_enable), 32'h0);
    check("sp_memon", 32'(mem_on),     32'h0);
    tick();
    pause = 1'b0; cam_valid = 2'b00;

    for (int i = 0; i < 3; i++) write_px(2'b01, 8'(i), 4'(i));
    // pause after three writes: valid pixels ignored
    pause = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cam_valid = 2'b01; cam0_data = 8'hEE;
      #1;
      check("pz_camen", 32'(cam_enable), 32'h0);
      check("pz_memon", 32'(mem_on),     32'h0);
      tick();
    end
    pause = 1'b0; cam_valid = 2'b00;
    for (int i = 3; i < 8; i++) begin
      if (i == 5) begin
        cam_valid = 2'b10; cam1_data = 8'hAA;
        #1;
        check("stray1_memon", 32'(mem_on),     32'h0);
        check("stray1_camen", 32'(cam_enable), 32'h1);
        tick();
      end
      write_px(2'b01, 8'(i), 4'(i));
    end
    // first CAP1 cycle: cam0 valid is now the inactive camera
    cam_valid = 2'b01; cam0_data = 8'h55;
    #1;
    check("stray0_memon", 32'(mem_on),     32'h0);
    check("cap1_camen",   32'(cam_enable), 32'h2);
    tick();
    for (int i = 0; i < 8; i++) write_px(2'b10, 8'h10 + 8'(i), 4'd8 + 4'(i));

    // readout with backpressure at pixel 3, a pause, and a stray start
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!bp_done && out_valid && idx == 3) begin
        bp_left = 5; bp_done = 1'b1;
      end
      out_ready = (bp_left == 0);
      pause = (pz_left > 0);
      start = (cyc == 4);
      #1;
      if (bp_left > 0) begin
        check("bp_hold",   32'(out_data),  32'h03);
        check("bp_valid",  32'(out_valid), 32'h1);
        check("bp_noread", 32'(mem_on),    32'h0);
        bp_left--;
      end
      if (pause) begin
        check("rd_pause_noread", 32'(mem_on), 32'h0);
        pz_left--;
      end
      if (mem_on) begin
        check("rd_rw", 32'(mem_rw), 32'h0);
        if (rd_k < 16) check("rd_addr", 32'(mem_addr), 32'(exp_addr[rd_k]));
        else check("rd_extra", 32'(rd_k), 32'd15);
        rd_k++;
      end
      if (out_valid && out_ready) begin
        if (idx < 16) check("out_data", 32'(out_data), 32'(exp_data[idx]));
        else check("out_extra", 32'(idx), 32'd15);
        idx++;
        if (idx == 10 && !pz_done) begin
          pz_left = 3; pz_done = 1'b1;
        end
      end
      if (done) done_cnt++;
      tick();
      if (!busy) break;
    end
    start = 1'b0; pause = 1'b0; out_ready = 1'b1;
    check("end_outcnt", 32'(idx),      32'd16);
    check("end_rdcnt",  32'(rd_k),     32'd16);
    check("end_done1",  32'(done_cnt), 32'd1);
    check("end_busy",   32'(busy),     32'h0);
    check("end_done0",  32'(done),     32'h0);
    check("end_oval",   32'(out_valid), 32'h0);
    check("checksum",   32'(checksum), 32'(exp_sum));
    tick();
    check("csum_hold",  32'(checksum), 32'(exp_sum));

    // asynchronous reset in the middle of CAP1
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) write_px(2'b01, 8'h20 + 8'(i), 4'(i));
    for (int i = 0; i < 2; i++) write_px(2'b10, 8'h30 + 8'(i), 4'd8 + 4'(i));
    cam_valid = 2'b10; cam1_data = 8'h32;
    #1;
    check("pre_rst_memon", 32'(mem_on), 32'h1);
    erst = 1'b0;
    #1;
    check("arst_busy",  32'(busy),       32'h0);
    check("arst_camen", 32'(cam_enable), 32'h0);
    check("arst_memon", 32'(mem_on),     32'h0);
    check("arst_done",  32'(done),       32'h0);
    tick();
    erst = 1'b1; cam_valid = 2'b00;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_done", 32'(done), 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
